rx_sync_fifo: RTL and testbench

Single-clock synchronous FIFO that buffers bytes from the UART receiver and feeds the memory controller's command/address/data parser. The producer side is driven by the UART receive valid/ready path. The consumer side presents the rx_fifo_empty / rx_fifo_rd_en / din interface the memory controller reads. Read data is registered and valid exactly one cycle after an accepted read.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/rx_sync_fifo_if.sv | 29 ++
 rtl/fifo_regfile.sv | 32 +++
 rtl/rx_sync_fifo.sv | 81 ++++++++
 tb/tb_rx_sync_fifo.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the UART receive FIFO.
package fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 32;

  // Pointer width carries one extra wrap bit above the storage index.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/rx_sync_fifo_if.sv
// Producer/consumer bus of the receive FIFO; master drives requests, slave is the FIFO.
interface rx_sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CNT_W = ptr_width(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             full;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, din, rd_en,
    input  full, dout, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output full, dout, empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_regfile.sv
// DEPTH x WIDTH storage: synchronous write port, registered read port with enable.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage carries no reset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/rx_sync_fifo.sv
// Single-clock receive FIFO between UART RX and the memory-controller parser.
// Optional sticky overflow/underflow flags: define FIFO_ERR_FLAGS_EN.
module rx_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  rx_sync_fifo_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int PTR_W      = ptr_width(DEPTH);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [WIDTH-1:0] w_dout;

  // Flags come only from registered pointers, never from the request inputs.
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]) &&
                    (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]);
  assign w_wr_acc = bus.wr_en && !w_full;
  assign w_rd_acc = bus.rd_en && !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + PTR_W'(1);
      if (w_rd_acc) r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  fifo_regfile #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wdata (bus.din),
    .i_re    (w_rd_acc),
    .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_dout)
  );

  assign bus.dout  = w_dout;
  assign bus.full  = w_full;
  assign bus.empty = w_empty;
  assign bus.count = r_wptr - r_rptr;

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr_en && w_full)  r_overflow  <= 1'b1;
      if (bus.rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_rx_sync_fifo.sv
// Directed bench for rx_sync_fifo; read data is checked by a queue-based monitor.
module tb_rx_sync_fifo;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_exp;
  logic       pend_rd = 1'b0;
  logic       mon_rd;

  rx_sync_fifo_if #(.WIDTH(8), .DEPTH(32)) bus ();

  rx_sync_fifo #(.WIDTH(8), .DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read the bench expects to be accepted shows up on dout one edge later.
  always @(posedge clk or negedge rst) begin
    if (!rst) mon_rd <= 1'b0;
    else      mon_rd <= pend_rd;
  end

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      last_exp = 8'h00;
    end else if (mon_rd) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dout_unexpected: got %0h expected none", bus.dout);
      end else begin
        last_exp = exp_q.pop_front();
        check("dout", {24'h0, bus.dout}, {24'h0, last_exp});
      end
    end else begin
      check("dout_hold", {24'h0, bus.dout}, {24'h0, last_exp});
    end
  end

  // One clock: drive requests, wait through the edge, return idle at the falling edge.
  task automatic step(input bit w, input logic [7:0] d, input bit r,
                      input bit e, input logic [7:0] ev);
    bus.wr_en = w;
    bus.din   = d;
    bus.rd_en = r;
    pend_rd   = e;
    if (e) exp_q.push_back(ev);
    @(posedge clk);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    pend_rd   = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [7:0] ev);
    step(1'b0, 8'h00, 1'b1, 1'b1, ev);
  endtask

  task automatic check_state(input string tag, input int cnt, input bit e, input bit f);
    check({tag, "_count"}, {26'h0, bus.count}, cnt);
    check({tag, "_empty"}, {31'h0, bus.empty}, {31'h0, e});
    check({tag, "_full"},  {31'h0, bus.full},  {31'h0, f});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = 8'h00;
    repeat (2) @(negedge clk);
    check_state("por", 0, 1'b1, 1'b0);
    check("por_dout", {24'h0, bus.dout}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Reset pulse between edges clears state without a clock.
    wr(8'hC1);
    wr(8'hC2);
    check_state("pre_pulse", 2, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1 check_state("pulse", 0, 1'b1, 1'b0);
    check("pulse_dout", {24'h0, bus.dout}, 32'h0);
    #1 rst = 1'b1;

    // Ordering.
    wr(8'h11); wr(8'h22); wr(8'h33);
    check_state("ord_wr", 3, 1'b0, 1'b0);
    rd(8'h11); rd(8'h22); rd(8'h33);
    check_state("ord_rd", 0, 1'b1, 1'b0);

    // Fill, overflow attempt, simultaneous at full, then wrap.
    for (int i = 0; i < 32; i++) wr(8'(i));
    check_state("fill", 32, 1'b0, 1'b1);
    wr(8'hAA);
    check_state("ovf", 32, 1'b0, 1'b1);
    check("overflow", {31'h0, bus.overflow}, {31'h0, ERR});
    step(1'b1, 8'hBB, 1'b1, 1'b1, 8'h00);
    check_state("full_both", 31, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) rd(8'(i));
    check_state("half", 16, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i));
    check_state("refill", 32, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) rd(8'(8'h10 + i));
    for (int i = 0; i < 16; i++) rd(8'(8'h40 + i));
    check_state("drain", 0, 1'b1, 1'b0);

    // Simultaneous at empty: write taken, read dropped, dout held.
    step(1'b1, 8'h5A, 1'b1, 1'b0, 8'h00);
    check_state("empty_both", 1, 1'b0, 1'b0);
    rd(8'h5A);
    check_state("empty_both_rd", 0, 1'b1, 1'b0);

    // Underflow: reads on empty are dropped.
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    check_state("udf", 0, 1'b1, 1'b0);
    check("underflow", {31'h0, bus.underflow}, {31'h0, ERR});
    wr(8'h99);
    rd(8'h99);
    check_state("udf_after", 0, 1'b1, 1'b0);

    // Reset mid-stream.
    for (int i = 0; i < 5; i++) wr(8'(8'hE0 + i));
    check_state("mid", 5, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 check_state("mid_rst", 0, 1'b1, 1'b0);
    check("mid_rst_dout", {24'h0, bus.dout}, 32'h0);
    check("mid_rst_ovf", {31'h0, bus.overflow}, 32'h0);
    check("mid_rst_udf", {31'h0, bus.underflow}, 32'h0);
    #1 rst = 1'b1;
    @(negedge clk);
    wr(8'h77);
    rd(8'h77);
    check_state("post_rst", 0, 1'b1, 1'b0);

    @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
